ct_spsram_256x84_ctrl: RTL

CT_SPSRAM_256X84_CTRL -- requirements
Module: ct_spsram_256x84_ctrl

---
 rtl/ct_spsram_256x84_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/ct_spsram_256x84_ctrl.sv
// Front-end controller for a 256x84 single-port SRAM: optional zero fill after
// reset, then a request/response port with per-bit write masks and one read in flight.
module ct_spsram_256x84_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 84,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q,
   output logic                  dbg_state
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_IDLE;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  rsp_vld_q, rsp_vld_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  in_init;
   logic                  in_idle;
   logic                  req_acc;

   // Handshakes: a request transfers on a cycle where req_vld & req_rdy, a
   // response on a cycle where rsp_vld & rsp_rdy; valid holds its payload until then.
   // State decodes are qualified by cpurst_b so outputs go quiet the instant reset asserts.
   assign in_init   = cpurst_b & (state_q == ST_INIT);
   assign in_idle   = cpurst_b & (state_q == ST_IDLE);
   assign req_rdy   = in_idle & ~rd_pend_q & (~rsp_vld_q | rsp_rdy);
   assign req_acc   = req_vld & req_rdy;
   assign init_done = in_idle;
   assign rsp_vld   = rsp_vld_q;
   assign rsp_rdata = rsp_rdata_q;
   assign dbg_state = (state_q == ST_IDLE);

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      rd_pend_d   = 1'b0;
      rsp_vld_d   = rsp_vld_q;
      rsp_rdata_d = rsp_rdata_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == '1) begin
            state_d = ST_IDLE;
         end
      end else begin
         rd_pend_d = req_acc & ~req_wr;
      end
      if (rsp_vld_q & rsp_rdy) begin
         rsp_vld_d = 1'b0;
      end
      // The SRAM returns read data one cycle after the access; capture wins over a consume.
      if (rd_pend_q) begin
         rsp_vld_d   = 1'b1;
         rsp_rdata_d = sram_q;
      end
   end

   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = '0;
      sram_d    = '0;
      if (in_init) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = init_cnt_q;
      end else if (req_acc) begin
         sram_cen  = 1'b0;
         sram_gwen = ~req_wr;
         sram_wen  = req_wr ? ~req_wmask : '1;
         sram_a    = req_addr;
         sram_d    = req_wdata;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q     <= RST_STATE;
         init_cnt_q  <= '0;
         rd_pend_q   <= 1'b0;
         rsp_vld_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         rd_pend_q   <= rd_pend_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule
